// File: rtl/bank_access_ctrl.sv
// Scratchpad bank access controller: arbitrates psum writes against LOAD/READ instructions.
// Optional perf_stall/perf_rows counters are built when BANK_ACCESS_PERF_EN is defined.
module bank_access_ctrl #(
  parameter  int NBANK  = 4,
  parameter  int ROW_W  = 5,
  parameter  int DATA_W = 128,
  parameter  int ADDR_W = 32,
  localparam int BW     = $clog2(NBANK)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              instr_empty,
  output logic              instr_ren,
  input  logic [1:0]        instr_op,
  input  logic [BW-1:0]     instr_bank,
  input  logic [ROW_W-1:0]  instr_row,
  input  logic [ROW_W:0]    instr_nrows,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic              psum_empty,
  output logic              psum_ren,
  input  logic [BW-1:0]     psum_bank,
  input  logic [ROW_W-1:0]  psum_row,
  input  logic [DATA_W-1:0] psum_data,
  output logic              sload_req,
  output logic [ADDR_W-1:0] sload_addr,
  input  logic              sload_hit,
  input  logic [DATA_W-1:0] sload_data,
  input  logic [NBANK-1:0]  wfifo_full,
  output logic [NBANK-1:0]  wfifo_wen,
  input  logic [NBANK-1:0]  rfifo_full,
  output logic [NBANK-1:0]  rfifo_wen,
  output logic [ROW_W-1:0]  bank_row,
  output logic [DATA_W-1:0] bank_wdata,
  output logic              busy
`ifdef BANK_ACCESS_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_rows
`endif
);

  typedef enum logic [1:0] {IDLE, LD_REQ, LD_WR, RD} state_t;

  localparam int             BYTES    = DATA_W / 8;
  localparam logic [ROW_W:0] MAX_ROWS = {1'b1, {ROW_W{1'b0}}};

  state_t              state_q, state_d;
  logic                pref_psum_q, pref_psum_d;
  logic [BW-1:0]       bank_q, bank_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ROW_W:0]      nrows_q, nrows_d, k_q, k_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                instr_cand, psum_cand, grant_psum, grant_instr, instr_ok;
  logic [ROW_W-1:0]    row_k;
  logic [ROW_W:0]      k_inc;

  assign instr_cand  = !instr_empty;
  assign psum_cand   = !psum_empty && !wfifo_full[psum_bank];
  assign grant_psum  = psum_cand && (!instr_cand || pref_psum_q);
  assign grant_instr = instr_cand && !grant_psum;
  assign instr_ok    = (instr_op == 2'd1 || instr_op == 2'd2) &&
                       (instr_nrows != '0) && (instr_nrows <= MAX_ROWS);
  assign row_k       = row_q + k_q[ROW_W-1:0];
  assign k_inc       = k_q + 1'b1;
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    pref_psum_d = pref_psum_q;
    bank_d      = bank_q;
    row_d       = row_q;
    nrows_d     = nrows_q;
    k_d         = k_q;
    addr_d      = addr_q;
    data_d      = data_q;
    instr_ren   = 1'b0;
    psum_ren    = 1'b0;
    sload_req   = 1'b0;
    sload_addr  = '0;
    wfifo_wen   = '0;
    rfifo_wen   = '0;
    bank_row    = '0;
    bank_wdata  = '0;
    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held so every output reads zero.
        if (nRST && grant_psum) begin
          psum_ren             = 1'b1;
          wfifo_wen[psum_bank] = 1'b1;
          bank_row             = psum_row;
          bank_wdata           = psum_data;
          pref_psum_d          = 1'b0;
        end else if (nRST && grant_instr) begin
          instr_ren   = 1'b1;
          pref_psum_d = 1'b1;
          bank_d      = instr_bank;
          row_d       = instr_row;
          nrows_d     = instr_nrows;
          addr_d      = instr_addr;
          k_d         = '0;
          if (instr_ok) state_d = (instr_op == 2'd1) ? LD_REQ : RD;
        end
      end
      LD_REQ: begin
        sload_req  = 1'b1;
        sload_addr = addr_q + ADDR_W'(k_q) * ADDR_W'(BYTES);
        if (sload_hit) begin
          data_d  = sload_data;
          state_d = LD_WR;
        end
      end
      LD_WR: begin
        if (!wfifo_full[bank_q]) begin
          wfifo_wen[bank_q] = 1'b1;
          bank_row          = row_k;
          bank_wdata        = data_q;
          k_d               = k_inc;
          state_d           = (k_inc == nrows_q) ? IDLE : LD_REQ;
        end
      end
      RD: begin
        if (!rfifo_full[bank_q]) begin
          rfifo_wen[bank_q] = 1'b1;
          bank_row          = row_k;
          k_d               = k_inc;
          if (k_inc == nrows_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      pref_psum_q <= 1'b1;
      bank_q      <= '0;
      row_q       <= '0;
      nrows_q     <= '0;
      k_q         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      pref_psum_q <= pref_psum_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      nrows_q     <= nrows_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

`ifdef BANK_ACCESS_PERF_EN
  logic [31:0] perf_stall_q, perf_rows_q;
  logic        stall_evt, row_evt;

  assign stall_evt = (state_q == LD_REQ && !sload_hit) ||
                     (state_q == LD_WR && wfifo_full[bank_q]) ||
                     (state_q == RD && rfifo_full[bank_q]);
  assign row_evt   = (|wfifo_wen) || (|rfifo_wen);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_stall_q <= '0;
      perf_rows_q  <= '0;
    end else begin
      if (stall_evt && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
      if (row_evt && perf_rows_q != '1)    perf_rows_q  <= perf_rows_q + 1'b1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_rows  = perf_rows_q;
`endif

endmodule

// File: tb/tb_bank_access_ctrl.sv
// Directed bench for bank_access_ctrl: scoreboard of expected bank pushes and load addresses.
module tb_bank_access_ctrl;

  typedef struct packed {
    logic         is_rd;
    logic [3:0]   wen;
    logic [4:0]   row;
    logic [127:0] data;
  } push_t;

  logic         CLK, nRST;
  logic         instr_empty, instr_ren;
  logic [1:0]   instr_op, instr_bank;
  logic [4:0]   instr_row;
  logic [5:0]   instr_nrows;
  logic [31:0]  instr_addr;
  logic         psum_empty, psum_ren;
  logic [1:0]   psum_bank;
  logic [4:0]   psum_row;
  logic [127:0] psum_data;
  logic         sload_req, sload_hit;
  logic [31:0]  sload_addr;
  logic [127:0] sload_data;
  logic [3:0]   wfifo_full, wfifo_wen, rfifo_full, rfifo_wen;
  logic [4:0]   bank_row;
  logic [127:0] bank_wdata;
  logic         busy;

  int    n_chk  = 0;
  int    n_fail = 0;
  int    wait_cnt = 0;
  push_t exp_q[$];
  logic [31:0] exp_addr[$];
  push_t obs_p, exp_p;

  bank_access_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .instr_empty(instr_empty), .instr_ren(instr_ren), .instr_op(instr_op),
    .instr_bank(instr_bank), .instr_row(instr_row), .instr_nrows(instr_nrows),
    .instr_addr(instr_addr),
    .psum_empty(psum_empty), .psum_ren(psum_ren), .psum_bank(psum_bank),
    .psum_row(psum_row), .psum_data(psum_data),
    .sload_req(sload_req), .sload_addr(sload_addr), .sload_hit(sload_hit),
    .sload_data(sload_data),
    .wfifo_full(wfifo_full), .wfifo_wen(wfifo_wen),
    .rfifo_full(rfifo_full), .rfifo_wen(rfifo_wen),
    .bank_row(bank_row), .bank_wdata(bank_wdata), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] a);
    return {4{a ^ 32'h5A5A_C3C3}};
  endfunction

  function automatic push_t mkp(input logic rd, input logic [3:0] wen,
                                input logic [4:0] row, input logic [127:0] data);
    push_t p;
    p.is_rd = rd; p.wen = wen; p.row = row; p.data = data;
    return p;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {instr_ren, psum_ren, sload_req, sload_addr, wfifo_wen, rfifo_wen,
              bank_row, bank_wdata, busy}, '0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] bank, input logic [4:0] row,
                       input logic [5:0] nrows, input logic [31:0] addr);
    step();
    instr_op = op; instr_bank = bank; instr_row = row;
    instr_nrows = nrows; instr_addr = addr; instr_empty = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (instr_ren) break;
    end
    chk("instr_grant", instr_ren, 1'b1);
    step();
    instr_empty = 1'b1;
    instr_op = 2'd0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy; i++) @(negedge CLK);
    chk("idle_timeout", busy, 1'b0);
  endtask

  // Memory model: answer each request after it has been held for two cycles.
  always @(negedge CLK) begin
    if (sload_hit) sload_hit = 1'b0;
    else if (nRST && sload_req) begin
      if (wait_cnt == 2) begin
        if (exp_addr.size() > 0) chk("sload_addr", sload_addr, exp_addr.pop_front());
        else chk("unexpected_load", sload_req, 1'b0);
        sload_data = mk(sload_addr);
        sload_hit  = 1'b1;
        wait_cnt   = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  always @(negedge CLK) begin
    if (nRST) begin
      chk("onehot_wen", ($countones({wfifo_wen, rfifo_wen}) <= 1), 1'b1);
      chk("onehot_ren", instr_ren & psum_ren, 1'b0);
      if (|wfifo_wen || |rfifo_wen) begin
        obs_p = mkp(|rfifo_wen, wfifo_wen | rfifo_wen, bank_row, bank_wdata);
        if (exp_q.size() == 0) chk("unexpected_push", obs_p, '0);
        else begin
          exp_p = exp_q.pop_front();
          chk("push", obs_p, exp_p);
        end
      end else begin
        chk("idle_row", bank_row, '0);
        chk("idle_wdata", bank_wdata, '0);
      end
      if (!sload_req) chk("idle_addr", sload_addr, '0);
    end
  end

  initial begin
    nRST = 1'b0;
    instr_empty = 1'b0; instr_op = 2'd2; instr_bank = 2'd1; instr_row = 5'd0;
    instr_nrows = 6'd1; instr_addr = '0;
    psum_empty = 1'b0; psum_bank = 2'd1; psum_row = 5'd2; psum_data = 128'h1234;
    sload_hit = 1'b0; sload_data = '0; wfifo_full = '0; rfifo_full = '0;
    #3;
    chk_zero("reset_outputs");
    repeat (2) @(posedge CLK);
    #1;
    instr_empty = 1'b1; psum_empty = 1'b1;
    nRST = 1'b1;
    @(negedge CLK);
    chk_zero("post_reset_idle");

    // LOAD bank2 rows 3..5 from 0x100
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(32'h100 + 32'(i) * 32'h10);
      exp_q.push_back(mkp(1'b0, 4'b0100, 5'(3 + i), mk(32'h100 + 32'(i) * 32'h10)));
    end
    issue(2'd1, 2'd2, 5'd3, 6'd3, 32'h100);
    chk("load_busy", busy, 1'b1);
    wait_idle(100);
    chk("load_sb_empty", exp_q.size() + exp_addr.size(), 0);

    // READ bank1 rows 30,31,0,1 on consecutive cycles
    exp_q.push_back(mkp(1'b1, 4'b0010, 5'd30, '0));
    exp_q.push_back(mkp(1'b1, 4'b0010, 5'd31, '0));
    exp_q.push_back(mkp(1'b1, 4'b0010, 5'd0, '0));
    exp_q.push_back(mkp(1'b1, 4'b0010, 5'd1, '0));
    issue(2'd2, 2'd1, 5'd30, 6'd4, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("rd_consec", rfifo_wen, 4'b0010);
      step();
    end
    @(negedge CLK);
    chk("rd_done", busy, 1'b0);
    chk("rd_sb_empty", exp_q.size(), 0);

    // Arbitration: both pending, grants alternate psum first
    step();
    exp_q.push_back(mkp(1'b0, 4'b1000, 5'd9, 128'hBEEF));
    exp_q.push_back(mkp(1'b0, 4'b1000, 5'd9, 128'hBEEF));
    psum_bank = 2'd3; psum_row = 5'd9; psum_data = 128'hBEEF; psum_empty = 1'b0;
    instr_op = 2'd0; instr_nrows = 6'd1; instr_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("rr_psum", psum_ren, (i % 2 == 0));
      chk("rr_instr", instr_ren, (i % 2 == 1));
      step();
    end
    psum_bank = 2'd0; wfifo_full = 4'b0001;
    @(negedge CLK);
    chk("full_psum_blocked", psum_ren, 1'b0);
    chk("full_instr_wins", instr_ren, 1'b1);
    step();
    instr_empty = 1'b1;
    @(negedge CLK);
    chk("full_psum_still", psum_ren, 1'b0);
    step();
    psum_empty = 1'b1; wfifo_full = '0;
    chk("rr_sb_empty", exp_q.size(), 0);

    // LOAD with the target write FIFO full, plus address wrap
    wfifo_full = 4'b0001;
    exp_addr.push_back(32'hFFFF_FFF0);
    exp_addr.push_back(32'h0);
    exp_q.push_back(mkp(1'b0, 4'b0001, 5'd7, mk(32'hFFFF_FFF0)));
    exp_q.push_back(mkp(1'b0, 4'b0001, 5'd8, mk(32'h0)));
    issue(2'd1, 2'd0, 5'd7, 6'd2, 32'hFFFF_FFF0);
    for (int i = 0; i < 50 && !(!sload_req && busy); i++) @(negedge CLK);
    chk("reach_ldwr", {sload_req, busy}, 2'b01);
    for (int i = 0; i < 5; i++) begin
      chk("ldwr_hold", {wfifo_wen, busy}, 5'b0000_1);
      @(negedge CLK);
    end
    step();
    wfifo_full = '0;
    @(negedge CLK);
    chk("ldwr_release_push", wfifo_wen, 4'b0001);
    wait_idle(100);
    chk("wrap_sb_empty", exp_q.size() + exp_addr.size(), 0);

    // Reset in the middle of a READ at k=2
    exp_q.push_back(mkp(1'b1, 4'b0100, 5'd0, '0));
    exp_q.push_back(mkp(1'b1, 4'b0100, 5'd1, '0));
    issue(2'd2, 2'd2, 5'd0, 6'd8, '0);
    step();
    step();
    nRST = 1'b0;
    #1;
    chk_zero("mid_rd_reset");
    step();
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("after_reset_quiet", {rfifo_wen, busy}, '0);
    end
    chk("reset_sb_empty", exp_q.size(), 0);

    // Consumed-without-effect instructions
    issue(2'd3, 2'd1, 5'd4, 6'd2, 32'h40);
    @(negedge CLK);
    chk_zero("op3_consumed");
    issue(2'd2, 2'd1, 5'd4, 6'd0, '0);
    @(negedge CLK);
    chk_zero("nrows0_consumed");
    issue(2'd1, 2'd1, 5'd4, 6'd33, 32'h80);
    @(negedge CLK);
    chk_zero("nrows_big_consumed");
    chk("final_sb_empty", exp_q.size() + exp_addr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
